// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two valid/ready write requesters, the registered
// register-file write port and the two read-hazard query ports.
interface regfile_wb_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] qa_addr;
    logic [AW-1:0] qb_addr;
    logic          stall_a;
    logic          stall_b;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output qa_addr, qb_addr,
        input  req0_ready, req1_ready,
        input  we, waddr, wdata,
        input  stall_a, stall_b
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  qa_addr, qb_addr,
        output req0_ready, req1_ready,
        output we, waddr, wdata,
        output stall_a, stall_b
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port.
// Define WB_RR_EN for round-robin on different-address contention (default: req1 > req0).
module regfile_wb_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    logic          pend0_q, pend0_d, pend1_q, pend1_d;
    logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic          old1_q, old1_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          grant0, grant1;
    logic          ready0, ready1;
    logic          load0, load1;
`ifdef WB_RR_EN
    logic          rr_q, rr_d;
    logic          contended;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef WB_RR_EN
        contended = 1'b0;
`endif
        if (pend0_q && pend1_q) begin
            if (addr0_q == addr1_q) begin
                grant1 = old1_q;
                grant0 = !old1_q;
            end else begin
`ifdef WB_RR_EN
                contended = 1'b1;
                grant0    = rr_q;
                grant1    = !rr_q;
`else
                grant1 = 1'b1;
`endif
            end
        end else begin
            grant0 = pend0_q;
            grant1 = pend1_q;
        end
    end

    assign ready0 = !pend0_q || grant0;
    assign ready1 = !pend1_q || grant1;
    // Address 0 completes the handshake but is dropped rather than held.
    assign load0  = bus.req0_valid && ready0 && (bus.req0_addr != '0);
    assign load1  = bus.req1_valid && ready1 && (bus.req1_addr != '0);

    always_comb begin
        pend0_d = load0 || (pend0_q && !grant0);
        pend1_d = load1 || (pend1_q && !grant1);
        addr0_d = load0 ? bus.req0_addr : addr0_q;
        data0_d = load0 ? bus.req0_data : data0_q;
        addr1_d = load1 ? bus.req1_addr : addr1_q;
        data1_d = load1 ? bus.req1_data : data1_q;
        // A fresh load is always younger than a surviving entry; a dual load makes req1 older.
        old1_d  = load0 ? 1'b1 : (load1 ? 1'b0 : old1_q);
        we_d    = grant0 || grant1;
        waddr_d = grant1 ? addr1_q : (grant0 ? addr0_q : waddr_q);
        wdata_d = grant1 ? data1_q : (grant0 ? data0_q : wdata_q);
`ifdef WB_RR_EN
        rr_d    = contended ? !rr_q : rr_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            addr0_q <= '0;
            data0_q <= '0;
            addr1_q <= '0;
            data1_q <= '0;
            old1_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef WB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            addr0_q <= addr0_d;
            data0_q <= data0_d;
            addr1_q <= addr1_d;
            data1_q <= data1_d;
            old1_q  <= old1_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef WB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;

    // The output register counts as in flight: the regfile has no bypass.
    assign bus.stall_a = (bus.qa_addr != '0) &&
                         ((pend0_q && (addr0_q == bus.qa_addr)) ||
                          (pend1_q && (addr1_q == bus.qa_addr)) ||
                          (we_q && (waddr_q == bus.qa_addr)));
    assign bus.stall_b = (bus.qb_addr != '0) &&
                         ((pend0_q && (addr0_q == bus.qb_addr)) ||
                          (pend1_q && (addr1_q == bus.qb_addr)) ||
                          (we_q && (waddr_q == bus.qb_addr)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based slot model.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.AW(5), .DW(32)) bus ();

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          checking = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each slot remembers when it was loaded; smaller seq is older.
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        int unsigned seq;
    } slot_t;

    slot_t       ms[2];
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_fav;
    int unsigned cyc;

    function automatic int model_grant();
        if (ms[0].v && ms[1].v) begin
            if (ms[0].a == ms[1].a) return (ms[0].seq < ms[1].seq) ? 0 : 1;
`ifdef WB_RR_EN
            return m_fav;
`else
            return 1;
`endif
        end
        if (ms[0].v) return 0;
        if (ms[1].v) return 1;
        return -1;
    endfunction

    function automatic bit model_stall(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        return (ms[0].v && ms[0].a == q) || (ms[1].v && ms[1].a == q) ||
               (m_we && m_waddr == q);
    endfunction

    always @(posedge clk) begin
        int g;
        bit r0, r1, v0, v1, contend;
        logic [4:0] a0, a1;
        logic [31:0] d0, d1;
        if (rst) begin
            ms[0].v = 0;
            ms[1].v = 0;
            m_we    = 0;
            m_waddr = '0;
            m_wdata = '0;
            m_fav   = 1;
        end else begin
            v0 = bus.req0_valid; a0 = bus.req0_addr; d0 = bus.req0_data;
            v1 = bus.req1_valid; a1 = bus.req1_addr; d1 = bus.req1_data;
            g  = model_grant();
            r0 = !ms[0].v || g == 0;
            r1 = !ms[1].v || g == 1;
            contend = ms[0].v && ms[1].v && ms[0].a != ms[1].a;
            m_we = (g >= 0);
            if (g >= 0) begin
                m_waddr = ms[g].a;
                m_wdata = ms[g].d;
                ms[g].v = 0;
            end
            if (contend) m_fav = (g == 0) ? 1 : 0;
            if (v1 && r1 && a1 != 0) ms[1] = '{1'b1, a1, d1, 2 * cyc};
            if (v0 && r0 && a0 != 0) ms[0] = '{1'b1, a0, d0, 2 * cyc + 1};
        end
        cyc++;
    end

    always @(negedge clk) begin
        int g;
        if (checking) begin
            g = model_grant();
            chk("ready0", 32'(bus.req0_ready), 32'(!ms[0].v || g == 0));
            chk("ready1", 32'(bus.req1_ready), 32'(!ms[1].v || g == 1));
            chk("we", 32'(bus.we), 32'(m_we));
            chk("waddr", 32'(bus.waddr), 32'(m_waddr));
            chk("wdata", bus.wdata, m_wdata);
            chk("stall_a", 32'(bus.stall_a), 32'(model_stall(bus.qa_addr)));
            chk("stall_b", 32'(bus.stall_b), 32'(model_stall(bus.qb_addr)));
        end
    end

    task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    task automatic idle();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.qa_addr = '0; bus.qb_addr = '0;
        do_reset();
        checking = 1'b1;
        @(negedge clk);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd1);

        // req0 alone, latency and stall through the output register
        bus.qa_addr = 5'd3;
        drive(1, 5'd3, 32'h11, 0, 5'd0, 32'd0);
        @(negedge clk); chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        idle();
        @(negedge clk); chk("t1_stall_pend", 32'(bus.stall_a), 32'd1);
        chk("t1_we_early", 32'(bus.we), 32'd0);
        @(negedge clk); chk("t1_we", 32'(bus.we), 32'd1);
        chk("t1_waddr", 32'(bus.waddr), 32'd3);
        chk("t1_wdata", bus.wdata, 32'h11);
        chk("t1_stall_out", 32'(bus.stall_a), 32'd1);
        @(negedge clk); chk("t1_we_off", 32'(bus.we), 32'd0);
        chk("t1_stall_off", 32'(bus.stall_a), 32'd0);

        // different-address contention
        do_reset();
        drive(1, 5'd4, 32'hA, 1, 5'd5, 32'hB);
        idle();
        @(negedge clk); chk("t2_we0", 32'(bus.we), 32'd0);
        @(negedge clk); chk("t2_waddr_first", 32'(bus.waddr), 32'd5);
        chk("t2_wdata_first", bus.wdata, 32'hB);
        @(negedge clk); chk("t2_we_second", 32'(bus.we), 32'd1);
        chk("t2_waddr_second", 32'(bus.waddr), 32'd4);
        chk("t2_wdata_second", bus.wdata, 32'hA);

        // same-address ordering
        do_reset();
        drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        idle();
        @(negedge clk);
        @(negedge clk); chk("t3_first", bus.wdata, 32'h2);
        @(negedge clk); chk("t3_final", bus.wdata, 32'h1);
        chk("t3_final_addr", 32'(bus.waddr), 32'd7);

        // address 0 accepted but never written
        do_reset();
        bus.qa_addr = 5'd0;
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hFF);
        @(negedge clk); chk("t4_ready1", 32'(bus.req1_ready), 32'd1);
        idle();
        @(negedge clk); chk("t4_we_a", 32'(bus.we), 32'd0);
        chk("t4_stall", 32'(bus.stall_a), 32'd0);
        @(negedge clk); chk("t4_we_b", 32'(bus.we), 32'd0);

        // back-to-back accepts on req1
        do_reset();
        drive(0, 5'd0, 32'd0, 1, 5'd1, 32'h101);
        @(negedge clk); chk("t5_ready_a", 32'(bus.req1_ready), 32'd1);
        drive(0, 5'd0, 32'd0, 1, 5'd2, 32'h102);
        @(negedge clk); chk("t5_ready_b", 32'(bus.req1_ready), 32'd1);
        drive(0, 5'd0, 32'd0, 1, 5'd3, 32'h103);
        @(negedge clk); chk("t5_ready_c", 32'(bus.req1_ready), 32'd1);
        chk("t5_we1", 32'(bus.we), 32'd1); chk("t5_waddr1", 32'(bus.waddr), 32'd1);
        idle();
        @(negedge clk); chk("t5_we2", 32'(bus.we), 32'd1); chk("t5_waddr2", 32'(bus.waddr), 32'd2);
        @(negedge clk); chk("t5_we3", 32'(bus.we), 32'd1); chk("t5_waddr3", 32'(bus.waddr), 32'd3);

        // reset with both entries pending
        do_reset();
        bus.qa_addr = 5'd9; bus.qb_addr = 5'd10;
        drive(1, 5'd9, 32'h9, 1, 5'd10, 32'hA0);
        idle();
        rst = 1'b1;
        @(negedge clk); chk("t6_stall_before", 32'(bus.stall_a), 32'd1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); chk("t6_we", 32'(bus.we), 32'd0);
        chk("t6_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t6_ready1", 32'(bus.req1_ready), 32'd1);
        chk("t6_stall_a", 32'(bus.stall_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t6_no_write", 32'(bus.we), 32'd0);
        end

        // randomized traffic with narrow address range to force collisions
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst            = ($urandom_range(0, 199) == 0);
            bus.req0_valid = $urandom_range(0, 1) == 1;
            bus.req0_addr  = 5'($urandom_range(0, 7));
            bus.req0_data  = $urandom;
            bus.req1_valid = $urandom_range(0, 1) == 1;
            bus.req1_addr  = 5'($urandom_range(0, 7));
            bus.req1_data  = $urandom;
            bus.qa_addr    = 5'($urandom_range(0, 7));
            bus.qb_addr    = 5'($urandom_range(0, 7));
        end
        idle();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
